// File: rtl/mem32_initiator.sv
// mem32_initiator: burst bus initiator for the mem32 byte-addressed responder.
// Takes one burst command (read/write, start byte address, word count) and moves
// one 32-bit word per memory access. Write words arrive on a valid/ready stream.
// Read words leave on a valid/ready stream.
// Ports:
//   clk, rst (synchronous, active-low)
//   req_valid/req_ready/req_write/req_addr/req_len  burst command
//   wdata_valid/wdata_ready/wdata                   write word stream in
//   rdata_valid/rdata_ready/rdata                   read word stream out
//   done/err                                        end-of-burst pulse, rejected-command flag
//   mem_wr/mem_rd/mem_addr/mem_wdata/mem_rdata      memory pins
module mem32_initiator #(
  parameter int unsigned MEM_BYTES = 11,
  parameter int unsigned LEN_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [31:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic             wdata_valid,
  output logic             wdata_ready,
  input  logic [31:0]      wdata,
  output logic             rdata_valid,
  input  logic             rdata_ready,
  output logic [31:0]      rdata,
  output logic             done,
  output logic             err,
  output logic             mem_wr,
  output logic             mem_rd,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  // Wide enough that addr + 4*len cannot wrap.
  localparam int unsigned EXT_W = 34;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ISSUE,
    RD_WAIT,
    RD_HOLD,
    DONE
  } state_t;

  state_t           state;
  logic [31:0]      addr;
  logic [LEN_W-1:0] count;

  logic [EXT_W-1:0] last_byte_c;
  logic             bad_cmd_c;

  // Command range check on the last byte touched by the burst.
  always_comb begin
    last_byte_c = EXT_W'(req_addr) + (EXT_W'(req_len) << 2) - EXT_W'(1);
    bad_cmd_c   = (req_len == '0) || (last_byte_c > EXT_W'(MEM_BYTES - 1));
  end

  // Burst sequencer; every output is a register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      addr        <= '0;
      count       <= '0;
      req_ready   <= 1'b0;
      wdata_ready <= 1'b0;
      rdata_valid <= 1'b0;
      rdata       <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      mem_wr      <= 1'b0;
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      mem_wr <= 1'b0;
      mem_rd <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            addr      <= req_addr;
            count     <= req_len;
            if (bad_cmd_c) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (req_write) begin
              state       <= WR;
              wdata_ready <= 1'b1;
            end else begin
              state    <= RD_ISSUE;
              mem_rd   <= 1'b1;
              mem_addr <= req_addr;
            end
          end
        end
        WR: begin
          if (count == '0) begin
            // Last mem_wr is on the pins this cycle; done follows it.
            state <= DONE;
            done  <= 1'b1;
          end else if (wdata_valid && wdata_ready) begin
            mem_wr    <= 1'b1;
            mem_addr  <= addr;
            mem_wdata <= wdata;
            addr      <= addr + 32'd4;
            count     <= count - LEN_W'(1);
            if (count == LEN_W'(1)) wdata_ready <= 1'b0;
          end
        end
        RD_ISSUE: state <= RD_WAIT;
        RD_WAIT: begin
          // Memory registers its read, so data is valid during this cycle.
          rdata       <= mem_rdata;
          rdata_valid <= 1'b1;
          state       <= RD_HOLD;
        end
        RD_HOLD: begin
          if (rdata_ready) begin
            rdata_valid <= 1'b0;
            addr        <= addr + 32'd4;
            count       <= count - LEN_W'(1);
            if (count == LEN_W'(1)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= RD_ISSUE;
              mem_rd   <= 1'b1;
              mem_addr <= addr + 32'd4;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem32_initiator.sv
// Testbench for mem32_initiator: byte memory model, transaction scoreboard
// checked every cycle, plus directed timing and data expectations.
module tb_mem32_initiator;
  localparam int unsigned MEM_BYTES = 11;
  localparam int unsigned LEN_W     = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req_valid = 1'b0, req_write = 1'b0;
  logic [31:0]      req_addr = '0;
  logic [LEN_W-1:0] req_len = '0;
  logic             wdata_valid = 1'b0;
  logic [31:0]      wdata = '0;
  logic             rdata_ready = 1'b0;
  logic [31:0]      mem_rdata = 32'hDEADBEEF;
  logic             req_ready, wdata_ready, rdata_valid, done, err, mem_wr, mem_rd;
  logic [31:0]      rdata, mem_addr, mem_wdata;

  always #5 clk = ~clk;

  mem32_initiator #(.MEM_BYTES(MEM_BYTES), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .done(done), .err(err),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int errors = 0;
  int checks = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Memory actually written by the DUT, and the bench's own reference copy.
  logic [7:0] mem     [MEM_BYTES];
  logic [7:0] ref_mem [MEM_BYTES];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w = '0;
    for (int k = 0; k < 4; k++)
      if (a + 32'(k) < MEM_BYTES) w[8*k +: 8] = mem[a + 32'(k)];
    return w;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] w = '0;
    for (int k = 0; k < 4; k++)
      if (a + 32'(k) < MEM_BYTES) w[8*k +: 8] = ref_mem[a + 32'(k)];
    return w;
  endfunction

  // Registered-read memory; idle bus value is a marker that must never be captured.
  always @(posedge clk) begin
    if (mem_wr)
      for (int k = 0; k < 4; k++)
        if (mem_addr + 32'(k) < MEM_BYTES) mem[mem_addr + 32'(k)] <= mem_wdata[8*k +: 8];
    mem_rdata <= mem_rd ? mem_word(mem_addr) : 32'hDEADBEEF;
  end

  // Scoreboard expectations and event logs.
  logic [31:0] exp_wr_addr[$], exp_wr_data[$], exp_rd_addr[$], exp_rdata[$];
  logic        exp_err[$];
  int unsigned wr_cyc[$], rd_cyc[$], rv_cyc[$], done_cyc[$];
  logic [31:0] rd_log[$];
  logic        err_log[$];
  int unsigned cyc = 0;
  int          done_cnt = 0;
  logic        rv_prev = 1'b0;
  logic        mon_en = 1'b0;
  logic [31:0] wd[16];

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process: every cycle, DUT pins against the transaction model.
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_wr || mem_rd) check("wr_rd_exclusive", 32'(mem_wr & mem_rd), 32'd0);
      if (mem_wr) begin
        wr_cyc.push_back(cyc);
        check("mem_wr_expected", 32'(exp_wr_addr.size() != 0), 32'd1);
        if (exp_wr_addr.size() != 0) begin
          check("mem_wr_addr", mem_addr, exp_wr_addr.pop_front());
          check("mem_wdata", mem_wdata, exp_wr_data.pop_front());
        end
      end
      if (mem_rd) begin
        rd_cyc.push_back(cyc);
        check("mem_rd_expected", 32'(exp_rd_addr.size() != 0), 32'd1);
        if (exp_rd_addr.size() != 0) check("mem_rd_addr", mem_addr, exp_rd_addr.pop_front());
      end
      if (rdata_valid && !rv_prev) rv_cyc.push_back(cyc);
      if (rdata_valid && rdata_ready) begin
        rd_log.push_back(rdata);
        check("rdata_expected", 32'(exp_rdata.size() != 0), 32'd1);
        if (exp_rdata.size() != 0) check("rdata", rdata, exp_rdata.pop_front());
      end
      if (done || err) check("err_implies_done", 32'(err & ~done), 32'd0);
      if (done) begin
        done_cyc.push_back(cyc);
        err_log.push_back(err);
        done_cnt++;
        check("done_expected", 32'(exp_err.size() != 0), 32'd1);
        if (exp_err.size() != 0) check("done_err", 32'(err), 32'(exp_err.pop_front()));
      end
      if (req_ready)
        check("idle_quiet", 32'({mem_wr, mem_rd, done, rdata_valid, wdata_ready}), 32'd0);
      rv_prev = rdata_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_cyc.delete(); rd_cyc.delete(); rv_cyc.delete(); done_cyc.delete();
    rd_log.delete(); err_log.delete();
  endtask

  // Issue a command; expectations come from the range rule and the reference memory.
  task automatic send_cmd(input logic w, input logic [31:0] a, input int unsigned len);
    logic bad;
    logic r;
    int   n;
    bad = (len == 0) || (longint'(a) + 4 * longint'(len) > longint'(MEM_BYTES));
    exp_err.push_back(bad);
    if (!bad && !w)
      for (int i = 0; i < int'(len); i++) begin
        exp_rd_addr.push_back(a + 32'(4 * i));
        exp_rdata.push_back(ref_word(a + 32'(4 * i)));
      end
    req_write = w; req_addr = a; req_len = LEN_W'(len); req_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk) r = req_ready;
      tick();
      n++;
    end while (!r && n < 40);
    check("req_handshake", 32'(r), 32'd1);
    req_valid = 1'b0;
  endtask

  // Stream wd[0..len-1]; gap_before[i] inserts one idle cycle before word i.
  task automatic write_words(input logic [31:0] a, input int unsigned len, input logic [15:0] gap_before);
    logic r;
    int   n;
    for (int i = 0; i < int'(len); i++) begin
      if (gap_before[i]) begin
        wdata_valid = 1'b0;
        tick();
      end
      wdata_valid = 1'b1;
      wdata = wd[i];
      n = 0;
      do begin
        @(negedge clk) r = wdata_ready;
        tick();
        n++;
      end while (!r && n < 40);
      check("wdata_handshake", 32'(r), 32'd1);
      exp_wr_addr.push_back(a + 32'(4 * i));
      exp_wr_data.push_back(wd[i]);
      for (int k = 0; k < 4; k++)
        if (a + 32'(4 * i + k) < MEM_BYTES) ref_mem[a + 32'(4 * i + k)] = wd[i][8*k +: 8];
    end
    wdata_valid = 1'b0;
  endtask

  task automatic wait_done();
    int prev = done_cnt;
    int n = 0;
    while (done_cnt == prev && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(done_cnt != prev), 32'd1);
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, 32'({req_ready, wdata_ready, rdata_valid, done, err, mem_wr, mem_rd}), 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_rdata"}, rdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev_done;
    int n;
    for (int i = 0; i < int'(MEM_BYTES); i++) begin
      mem[i] = 8'hA0 + 8'(i);
      ref_mem[i] = 8'hA0 + 8'(i);
    end

    // Reset state
    tick(); tick();
    @(negedge clk);
    check_reset_outputs("reset");
    tick();
    rst = 1'b1;
    mon_en = 1'b1;

    // Write burst addr 0, two words, valid every cycle
    clear_logs();
    wd[0] = 32'h11223344; wd[1] = 32'h55667788;
    send_cmd(1'b1, 32'd0, 2);
    write_words(32'd0, 2, 16'h0000);
    wait_done();
    check("t1_wr_count", 32'(wr_cyc.size()), 32'd2);
    if (wr_cyc.size() == 2) begin
      check("t1_wr_back_to_back", wr_cyc[1] - wr_cyc[0], 32'd1);
      if (done_cyc.size() == 1) check("t1_done_after_last_wr", done_cyc[0] - wr_cyc[1], 32'd1);
    end
    check("t1_mem_word0", mem_word(32'd0), 32'h11223344);
    check("t1_mem_word1", mem_word(32'd4), 32'h55667788);

    // Read back the same two words
    clear_logs();
    rdata_ready = 1'b1;
    send_cmd(1'b0, 32'd0, 2);
    wait_done();
    rdata_ready = 1'b0;
    check("t1r_rd_count", 32'(rd_cyc.size()), 32'd2);
    if (rd_cyc.size() != 0 && rv_cyc.size() != 0) check("t1r_latency", rv_cyc[0] - rd_cyc[0], 32'd2);
    check("t1r_word_count", 32'(rd_log.size()), 32'd2);
    if (rd_log.size() == 2) begin
      check("t1r_word0", rd_log[0], 32'h11223344);
      check("t1r_word1", rd_log[1], 32'h55667788);
    end

    // Read addr 4 with rdata_ready low for 5 cycles
    clear_logs();
    send_cmd(1'b0, 32'd4, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdata_valid && n < 20);
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clk);
      check("t2_valid_held", 32'(rdata_valid), 32'd1);
      check("t2_rdata_stable", rdata, 32'h55667788);
    end
    tick();
    rdata_ready = 1'b1;
    wait_done();
    rdata_ready = 1'b0;
    check("t2_single_rd", 32'(rd_cyc.size()), 32'd1);

    // Out-of-range command: addr 8 needs byte 11
    clear_logs();
    send_cmd(1'b1, 32'd8, 1);
    wait_done();
    check("t3_no_mem_access", 32'(wr_cyc.size() + rd_cyc.size()), 32'd0);
    if (err_log.size() != 0) check("t3_err_with_done", 32'(err_log[0]), 32'd1);

    // Zero-length command
    clear_logs();
    send_cmd(1'b0, 32'd0, 0);
    wait_done();
    check("t4_no_mem_access", 32'(wr_cyc.size() + rd_cyc.size()), 32'd0);
    if (err_log.size() != 0) check("t4_err_with_done", 32'(err_log[0]), 32'd1);

    // Reset after the first word of a write burst
    clear_logs();
    wd[0] = 32'hA5A50001; wd[1] = 32'hA5A50002;
    send_cmd(1'b1, 32'd0, 2);
    write_words(32'd0, 1, 16'h0000);
    prev_done = done_cnt;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("t5_reset");
    exp_err.delete();
    exp_wr_addr.delete();
    exp_wr_data.delete();
    tick(); tick();
    check("t5_no_done", 32'(done_cnt - prev_done), 32'd0);
    check("t5_one_wr", 32'(wr_cyc.size()), 32'd1);
    wd[0] = 32'hCAFEF00D;
    send_cmd(1'b1, 32'd4, 1);
    write_words(32'd4, 1, 16'h0000);
    wait_done();
    clear_logs();
    rdata_ready = 1'b1;
    send_cmd(1'b0, 32'd0, 2);
    wait_done();
    rdata_ready = 1'b0;
    if (rd_log.size() == 2) begin
      check("t5_word0", rd_log[0], 32'hA5A50001);
      check("t5_word1", rd_log[1], 32'hCAFEF00D);
    end

    // Unaligned write with wdata_valid 1,0,1
    clear_logs();
    wd[0] = 32'h0BADCAFE; wd[1] = 32'h12345678;
    send_cmd(1'b1, 32'd2, 2);
    write_words(32'd2, 2, 16'h0002);
    wait_done();
    check("t6_wr_count", 32'(wr_cyc.size()), 32'd2);
    if (wr_cyc.size() == 2) check("t6_wr_gap", wr_cyc[1] - wr_cyc[0], 32'd2);
    check("t6_no_rd", 32'(rd_cyc.size()), 32'd0);
    clear_logs();
    rdata_ready = 1'b1;
    send_cmd(1'b0, 32'd2, 2);
    wait_done();
    rdata_ready = 1'b0;
    if (rd_log.size() == 2) begin
      check("t6_word0", rd_log[0], 32'h0BADCAFE);
      check("t6_word1", rd_log[1], 32'h12345678);
    end

    tick(); tick();
    check("leftover_expectations",
          32'(exp_wr_addr.size() + exp_rd_addr.size() + exp_rdata.size() + exp_err.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
